// File: rtl/servo_pwm_multi_if.sv
// Write port and pulse/debug outputs of the multi-channel servo PWM generator.
// The controller side drives writes (master); the generator drives outputs (slave).
interface servo_pwm_multi_if #(
    parameter int NUM_CH       = 4,
    parameter int DUTY_W       = 8,
    parameter int PERIOD_TICKS = 2560
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(PERIOD_TICKS);

    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [DUTY_W-1:0] wr_duty;
    logic              wr_chen;
    logic [NUM_CH-1:0] pwm_out;
    logic              tick;
    logic              frame_start;
    logic [CNT_W-1:0]  frame_cnt;

    modport master (
        output wr_en, wr_ch, wr_duty, wr_chen,
        input  pwm_out, tick, frame_start, frame_cnt
    );

    modport slave (
        input  wr_en, wr_ch, wr_duty, wr_chen,
        output pwm_out, tick, frame_start, frame_cnt
    );
endinterface

// File: rtl/servo_pwm_multi.sv
// NUM_CH servo pulse outputs sharing one prescaler and frame counter; per-channel
// duty/enable are double-buffered and committed only when the frame counter wraps.
module servo_pwm_multi #(
    parameter int NUM_CH       = 4,
    parameter int DUTY_W       = 8,
    parameter int TICK_DIV     = 391,
    parameter int PERIOD_TICKS = 2560,
    parameter int MIN_TICKS    = 64
) (
    input  logic             clk,
    input  logic             reset,
    servo_pwm_multi_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(PERIOD_TICKS);
    localparam int PRE_W = $clog2(TICK_DIV);

    if (NUM_CH < 1 || NUM_CH > 16) begin : gChCheck
        $error("servo_pwm_multi: NUM_CH must be 1..16");
    end
    if (TICK_DIV < 2) begin : gDivCheck
        $error("servo_pwm_multi: TICK_DIV must be at least 2");
    end
    if (MIN_TICKS + (1 << DUTY_W) - 1 >= PERIOD_TICKS) begin : gPeriodCheck
        $error("servo_pwm_multi: longest pulse does not fit in the frame");
    end

    // Widened so MIN_TICKS plus the largest duty never wraps.
    function automatic logic [CNT_W:0] onTicks(input logic [DUTY_W-1:0] duty);
        return (CNT_W+1)'(MIN_TICKS) + (CNT_W+1)'(duty);
    endfunction

    logic [PRE_W-1:0]  preCnt;
    logic [CNT_W-1:0]  frameCnt;
    logic [CNT_W-1:0]  frameCntNext;
    logic [DUTY_W-1:0] pendingDuty    [NUM_CH];
    logic [DUTY_W-1:0] activeDuty     [NUM_CH];
    logic [DUTY_W-1:0] activeDutyNext [NUM_CH];
    logic [NUM_CH-1:0] pendingEn;
    logic [NUM_CH-1:0] activeEn;
    logic [NUM_CH-1:0] activeEnNext;
    logic [NUM_CH-1:0] pwmNext;
    logic [NUM_CH-1:0] pwmReg;
    logic              tickInt;
    logic              frameWrap;

    assign tickInt   = !reset && (preCnt == PRE_W'(TICK_DIV - 1));
    assign frameWrap = tickInt && (frameCnt == CNT_W'(PERIOD_TICKS - 1));

    // Outputs are decided from next-state counter and active settings so the
    // pulse rises on the very edge the frame counter returns to zero.
    always_comb begin
        frameCntNext = frameCnt;
        if (tickInt) begin
            frameCntNext = frameWrap ? '0 : frameCnt + CNT_W'(1);
        end
        activeEnNext = frameWrap ? pendingEn : activeEn;
        for (int i = 0; i < NUM_CH; i++) begin
            activeDutyNext[i] = frameWrap ? pendingDuty[i] : activeDuty[i];
            pwmNext[i] = activeEnNext[i] &&
                         ({1'b0, frameCntNext} < onTicks(activeDutyNext[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preCnt    <= '0;
            frameCnt  <= '0;
            pendingEn <= '0;
            activeEn  <= '0;
            pwmReg    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pendingDuty[i] <= '0;
                activeDuty[i]  <= '0;
            end
        end else begin
            preCnt   <= tickInt ? '0 : preCnt + PRE_W'(1);
            frameCnt <= frameCntNext;
            activeEn <= activeEnNext;
            pwmReg   <= pwmNext;
            // Commit above reads the old pending value, so a write on the
            // wrap edge lands in pending and waits for the next frame.
            for (int i = 0; i < NUM_CH; i++) begin
                activeDuty[i] <= activeDutyNext[i];
                if (bus.wr_en && (int'(bus.wr_ch) == i)) begin
                    pendingDuty[i] <= bus.wr_duty;
                    pendingEn[i]   <= bus.wr_chen;
                end
            end
        end
    end

    assign bus.tick        = tickInt;
    assign bus.frame_start = frameWrap;
    assign bus.frame_cnt   = frameCnt;
    assign bus.pwm_out     = pwmReg;
endmodule
